// File: rtl/booth_mult_share_arbiter.sv
// Round-robin scheduler sharing one pipelined Booth multiplier between NREQ requesters.
// Tags ride a shift pipeline aligned with the multiplier; results return in order via a shared FIFO.
module booth_mult_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NREQ     = 4,
  parameter int LATENCY  = 6,
  parameter int RQ_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_sign_mode,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic                  m_valid_in,
  output logic [WIDTH-1:0]      m_multiplicand,
  output logic [WIDTH-1:0]      m_multiplier,
  output logic [1:0]            m_sign_mode,
  input  logic                  m_valid_out,
  input  logic [2*WIDTH-1:0]    m_product,
  output logic                  busy,
  output logic                  err_sync
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(RQ_DEPTH + 1);
  localparam int AW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int DW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int PS = LATENCY + 1;

  logic [DW-1:0]      drain_q, drain_d;
  logic [TW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic [CW-1:0]      fifo_count_q, fifo_count_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PS-1:0]      tag_vld_q, tag_vld_d;
  logic [TW-1:0]      tag_pipe_q [PS];
  logic [TW-1:0]      tag_pipe_d [PS];
  logic [TW-1:0]      fifo_tag_q [RQ_DEPTH];
  logic [TW-1:0]      fifo_tag_d [RQ_DEPTH];
  logic [2*WIDTH-1:0] fifo_prod_q [RQ_DEPTH];
  logic [2*WIDTH-1:0] fifo_prod_d [RQ_DEPTH];
  logic               m_valid_in_q, m_valid_in_d;
  logic [WIDTH-1:0]   m_a_q, m_a_d, m_b_q, m_b_d;
  logic [1:0]         m_sm_q, m_sm_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   a_arr [NREQ];
  logic [WIDTH-1:0]   b_arr [NREQ];
  logic [1:0]         sm_arr [NREQ];
  logic               drain_done, credit_ok, allow, grant_valid, fifo_empty;
  logic               push, pop, drop_tag, spurious, retire;
  logic [TW-1:0]      grant_idx, cand;
  logic [CW:0]        occupancy;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i]  = req_a[i*WIDTH +: WIDTH];
      b_arr[i]  = req_b[i*WIDTH +: WIDTH];
      sm_arr[i] = req_sign_mode[i*2 +: 2];
    end
  end

  // Arbitration: first valid requester at or after ptr, gated by drain and credit.
  always_comb begin
    drain_done  = (drain_q == '0);
    occupancy   = {1'b0, fifo_count_q} + {1'b0, inflight_q};
    credit_ok   = occupancy < (CW+1)'(RQ_DEPTH);
    allow       = drain_done && credit_ok;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = TW'((int'(ptr_q) + k) % NREQ);
      if (!grant_valid && allow && req_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    req_ready = grant_valid ? (NREQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    fifo_empty  = (fifo_count_q == '0);
    rsp_valid   = fifo_empty ? '0 : (NREQ'(1) << fifo_tag_q[rd_ptr_q]);
    rsp_product = fifo_empty ? '0 : fifo_prod_q[rd_ptr_q];
    pop         = |(rsp_valid & rsp_ready);
    push        = drain_done && m_valid_out && tag_vld_q[PS-1];
    drop_tag    = drain_done && !m_valid_out && tag_vld_q[PS-1];
    spurious    = drain_done && m_valid_out && !tag_vld_q[PS-1];
    retire      = push || drop_tag;

    drain_d      = drain_done ? drain_q : drain_q - DW'(1);
    ptr_d        = ptr_q;
    m_valid_in_d = grant_valid;
    m_a_d        = m_a_q;
    m_b_d        = m_b_q;
    m_sm_d       = m_sm_q;
    if (grant_valid) begin
      ptr_d  = (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + TW'(1);
      m_a_d  = a_arr[grant_idx];
      m_b_d  = b_arr[grant_idx];
      m_sm_d = sm_arr[grant_idx];
    end

    tag_vld_d     = {tag_vld_q[PS-2:0], grant_valid};
    tag_pipe_d[0] = grant_idx;
    for (int i = 1; i < PS; i++) tag_pipe_d[i] = tag_pipe_q[i-1];

    inflight_d = inflight_q;
    if (grant_valid && !retire)      inflight_d = inflight_q + CW'(1);
    else if (!grant_valid && retire) inflight_d = inflight_q - CW'(1);

    fifo_count_d = fifo_count_q;
    if (push && !pop)      fifo_count_d = fifo_count_q + CW'(1);
    else if (!push && pop) fifo_count_d = fifo_count_q - CW'(1);

    fifo_tag_d  = fifo_tag_q;
    fifo_prod_d = fifo_prod_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_tag_d[wr_ptr_q]  = tag_pipe_q[PS-1];
      fifo_prod_d[wr_ptr_q] = m_product;
      wr_ptr_d = (wr_ptr_q == AW'(RQ_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == AW'(RQ_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);

    err_d = err_q || spurious || drop_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_q      <= DW'(LATENCY);
      ptr_q        <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_vld_q    <= '0;
      for (int i = 0; i < PS; i++) tag_pipe_q[i] <= '0;
      m_valid_in_q <= 1'b0;
      m_a_q        <= '0;
      m_b_q        <= '0;
      m_sm_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      drain_q      <= drain_d;
      ptr_q        <= ptr_d;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_vld_q    <= tag_vld_d;
      tag_pipe_q   <= tag_pipe_d;
      m_valid_in_q <= m_valid_in_d;
      m_a_q        <= m_a_d;
      m_b_q        <= m_b_d;
      m_sm_q       <= m_sm_d;
      err_q        <= err_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    fifo_tag_q  <= fifo_tag_d;
    fifo_prod_q <= fifo_prod_d;
  end

  assign m_valid_in     = m_valid_in_q;
  assign m_multiplicand = m_a_q;
  assign m_multiplier   = m_b_q;
  assign m_sign_mode    = m_sm_q;
  assign busy           = (inflight_q != '0) || (fifo_count_q != '0);
  assign err_sync       = err_q;
endmodule
